// File: rtl/alu_op_sequencer.sv
// Front-end sequencer: collects A, B and opcode from the switch bank one enter press at a time,
// issues the operation to the shared ALU and holds the captured result for display.
module alu_op_sequencer #(
    parameter int unsigned NUM_OPS     = 8,
    parameter int unsigned ALU_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enter,
    input  logic [7:0]  switch,
    input  logic [15:0] alu_result,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_op,
    output logic        alu_go,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        err,
    output logic        overrun
);

    typedef enum logic [2:0] {
        LOAD_A,
        LOAD_B,
        LOAD_OP,
        EXEC,
        SHOW
    } state_t;

    localparam logic [3:0] LAT4 = 4'(ALU_LATENCY);

    state_t      state_q, state_d;
    logic        sync1_q, sync2_q, prev_q, ent_p_q;
    logic [1:0]  settle_q;
    logic        armed_q;
    logic [7:0]  a_q, a_d, b_q, b_d;
    logic [3:0]  op_q, op_d, cnt_q, cnt_d;
    logic [15:0] res_q, res_d;
    logic        rv_q, rv_d, go_q, go_d, busy_q, busy_d;
    logic        err_q, err_d, ovr_q, ovr_d;
    logic        op_legal;

    // The edge detector stays disarmed until the synchronised button has been seen low
    // after reset, so a button held through reset release is not taken as a press.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            prev_q   <= 1'b0;
            ent_p_q  <= 1'b0;
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            sync1_q  <= enter;
            sync2_q  <= sync1_q;
            prev_q   <= sync2_q;
            ent_p_q  <= sync2_q & ~prev_q & armed_q;
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && !sync2_q) begin
                armed_q <= 1'b1;
            end
        end
    end

    assign op_legal = (switch[7:4] == 4'd0) && (32'(switch[3:0]) < NUM_OPS);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        res_d   = res_q;
        rv_d    = rv_q;
        err_d   = err_q;
        ovr_d   = ovr_q;
        case (state_q)
            LOAD_A, SHOW: begin
                if (ent_p_q) begin
                    a_d     = switch;
                    rv_d    = 1'b0;
                    err_d   = 1'b0;
                    ovr_d   = 1'b0;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (ent_p_q) begin
                    b_d     = switch;
                    state_d = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (ent_p_q) begin
                    if (op_legal) begin
                        op_d    = switch[3:0];
                        err_d   = 1'b0;
                        cnt_d   = LAT4;
                        state_d = EXEC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (ent_p_q) begin
                    ovr_d = 1'b1;
                end
                if (cnt_q == 4'd0) begin
                    res_d   = alu_result;
                    rv_d    = 1'b1;
                    state_d = SHOW;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = LOAD_A;
        endcase
        go_d   = (state_d == EXEC) && (state_q != EXEC);
        busy_d = (state_d == EXEC);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            res_q   <= '0;
            rv_q    <= 1'b0;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            rv_q    <= rv_d;
            go_q    <= go_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end

    assign alu_a        = a_q;
    assign alu_b        = b_q;
    assign alu_op       = op_q;
    assign alu_go       = go_q;
    assign result       = res_q;
    assign result_valid = rv_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign overrun      = ovr_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: instance 0 runs with ALU_LATENCY=1, instance 1 with ALU_LATENCY=5, each fed by
// an ALU stub whose output is only valid exactly ALU_LATENCY cycles after alu_go.
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sw;
    logic        enter_w   [2];
    logic [15:0] alu_res_w [2];
    logic [7:0]  a_w       [2];
    logic [7:0]  b_w       [2];
    logic [3:0]  op_w      [2];
    logic        go_w      [2];
    logic [15:0] res_w     [2];
    logic        rv_w      [2];
    logic        busy_w    [2];
    logic        err_w     [2];
    logic        ovr_w     [2];
    int unsigned age       [2];
    int          gocnt     [2];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.NUM_OPS(8), .ALU_LATENCY(1)) u_lat1 (
        .clk(clk), .rst(rst), .enter(enter_w[0]), .switch(sw), .alu_result(alu_res_w[0]),
        .alu_a(a_w[0]), .alu_b(b_w[0]), .alu_op(op_w[0]), .alu_go(go_w[0]), .result(res_w[0]),
        .result_valid(rv_w[0]), .busy(busy_w[0]), .err(err_w[0]), .overrun(ovr_w[0])
    );

    alu_op_sequencer #(.NUM_OPS(8), .ALU_LATENCY(5)) u_lat5 (
        .clk(clk), .rst(rst), .enter(enter_w[1]), .switch(sw), .alu_result(alu_res_w[1]),
        .alu_a(a_w[1]), .alu_b(b_w[1]), .alu_op(op_w[1]), .alu_go(go_w[1]), .result(res_w[1]),
        .result_valid(rv_w[1]), .busy(busy_w[1]), .err(err_w[1]), .overrun(ovr_w[1])
    );

    function automatic logic [15:0] stub(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        case (op)
            4'd0:    stub = {8'd0, a} + {8'd0, b};
            4'd1:    stub = {8'd0, a} - {8'd0, b};
            4'd2:    stub = {8'd0, a} * {8'd0, b};
            4'd3:    stub = {8'd0, a & b};
            4'd4:    stub = {8'd0, a | b};
            4'd5:    stub = {8'd0, a ^ b};
            4'd6:    stub = {a, b};
            default: stub = {b, a};
        endcase
    endfunction

    initial begin
        gocnt[0] = 0;
        gocnt[1] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) age[i] <= 0;
            else if (go_w[i]) age[i] <= 1;
            else if (age[i] != 0 && age[i] < 100) age[i] <= age[i] + 1;
            if (go_w[i]) gocnt[i] <= gocnt[i] + 1;
        end
    end

    assign alu_res_w[0] = (age[0] == 1) ? stub(a_w[0], b_w[0], op_w[0]) : 16'hDEAD;
    assign alu_res_w[1] = (age[1] == 5) ? stub(a_w[1], b_w[1], op_w[1]) : 16'hDEAD;

    task automatic press(input int w, input logic [7:0] v);
        sw = v;
        enter_w[w] = 1'b1;
        repeat (2) @(negedge clk);
        enter_w[w] = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic wait_rv(input int w, input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (rv_w[w]) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        sw = 8'h5A;
        enter_w[0] = 1'b1;
        enter_w[1] = 1'b0;
        repeat (5) @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            tests++;
            if ({a_w[w], b_w[w], op_w[w], go_w[w], res_w[w], rv_w[w], busy_w[w], err_w[w], ovr_w[w]} !== 42'd0) begin
                fails++;
                $display("FAIL reset_outputs[%0d] a=%h b=%h op=%h go=%b res=%h rv=%b busy=%b err=%b ovr=%b required all 0",
                         w, a_w[w], b_w[w], op_w[w], go_w[w], res_w[w], rv_w[w], busy_w[w], err_w[w], ovr_w[w]);
            end
        end
        rst = 1'b0;
        repeat (8) @(negedge clk);
        tests++;
        if (a_w[0] !== 8'h00) begin
            fails++;
            $display("FAIL held_enter_no_load got a=%h required 00", a_w[0]);
        end
        enter_w[0] = 1'b0;
        repeat (3) @(negedge clk);
        press(0, 8'h5A);
        tests++;
        if (a_w[0] !== 8'h5A) begin
            fails++;
            $display("FAIL reload_after_release got a=%h required 5a", a_w[0]);
        end
    endtask

    task automatic test_full_op();
        int         g0;
        int         seen;
        logic [2:0] rvs;
        do_reset();
        press(0, 8'h12);
        press(0, 8'h34);
        tests++;
        if (a_w[0] !== 8'h12 || b_w[0] !== 8'h34) begin
            fails++;
            $display("FAIL operands got a=%h b=%h required 12 34", a_w[0], b_w[0]);
        end
        g0 = gocnt[0];
        seen = -1;
        rvs = 3'b111;
        sw = 8'h02;
        enter_w[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) enter_w[0] = 1'b0;
            if (seen < 0 && busy_w[0]) seen = i;
            if (seen > 0 && i - seen <= 2) rvs[i - seen] = rv_w[0];
        end
        tests++;
        if (seen < 0 || rvs !== 3'b100) begin
            fails++;
            $display("FAIL rv_latency got busy_seen=%0d rv_offsets=%b required seen>0 and 100", seen, rvs);
        end
        tests++;
        if (res_w[0] !== 16'h03A8) begin
            fails++;
            $display("FAIL mul_result got %h required 03a8", res_w[0]);
        end
        tests++;
        if (gocnt[0] - g0 !== 1 || op_w[0] !== 4'd2) begin
            fails++;
            $display("FAIL go_pulses got %0d op=%h required 1 op=2", gocnt[0] - g0, op_w[0]);
        end
    endtask

    task automatic test_show_restart();
        bit ok;
        press(0, 8'hFF);
        tests++;
        if (a_w[0] !== 8'hFF || rv_w[0] !== 1'b0 || res_w[0] !== 16'h03A8) begin
            fails++;
            $display("FAIL show_restart got a=%h rv=%b res=%h required ff 0 03a8", a_w[0], rv_w[0], res_w[0]);
        end
        press(0, 8'h02);
        sw = 8'h00;
        enter_w[0] = 1'b1;
        repeat (2) @(negedge clk);
        enter_w[0] = 1'b0;
        wait_rv(0, 12, ok);
        tests++;
        if (!ok || res_w[0] !== 16'h0101) begin
            fails++;
            $display("FAIL restart_from_load_b got ok=%b res=%h required 1 0101", ok, res_w[0]);
        end
    endtask

    task automatic test_illegal_op();
        int g0;
        bit ok;
        do_reset();
        press(0, 8'h07);
        press(0, 8'h05);
        g0 = gocnt[0];
        press(0, 8'h09);
        tests++;
        if (err_w[0] !== 1'b1 || busy_w[0] !== 1'b0 || op_w[0] !== 4'd0 || gocnt[0] !== g0) begin
            fails++;
            $display("FAIL illegal_09 got err=%b busy=%b op=%h go=%0d required 1 0 0 0", err_w[0], busy_w[0], op_w[0], gocnt[0] - g0);
        end
        press(0, 8'h03);
        wait_rv(0, 10, ok);
        tests++;
        if (!ok || err_w[0] !== 1'b0 || res_w[0] !== 16'h0005 || gocnt[0] - g0 !== 1) begin
            fails++;
            $display("FAIL legal_after_illegal got ok=%b err=%b res=%h go=%0d required 1 0 0005 1", ok, err_w[0], res_w[0], gocnt[0] - g0);
        end
        press(0, 8'h21);
        press(0, 8'h03);
        g0 = gocnt[0];
        press(0, 8'h17);
        tests++;
        if (err_w[0] !== 1'b1 || op_w[0] !== 4'd3 || gocnt[0] !== g0) begin
            fails++;
            $display("FAIL illegal_high_nibble got err=%b op=%h go=%0d required 1 3 0", err_w[0], op_w[0], gocnt[0] - g0);
        end
        press(0, 8'h08);
        tests++;
        if (err_w[0] !== 1'b1 || gocnt[0] !== g0) begin
            fails++;
            $display("FAIL illegal_08 got err=%b go=%0d required 1 0", err_w[0], gocnt[0] - g0);
        end
        press(0, 8'h07);
        wait_rv(0, 10, ok);
        tests++;
        if (!ok || err_w[0] !== 1'b0 || res_w[0] !== 16'h0321 || op_w[0] !== 4'd7) begin
            fails++;
            $display("FAIL max_legal_op got ok=%b err=%b res=%h op=%h required 1 0 0321 7", ok, err_w[0], res_w[0], op_w[0]);
        end
    endtask

    task automatic test_overrun();
        int g0;
        do_reset();
        press(1, 8'h10);
        press(1, 8'h03);
        g0 = gocnt[1];
        press(1, 8'h00);
        tests++;
        if (busy_w[1] !== 1'b1 || rv_w[1] !== 1'b0) begin
            fails++;
            $display("FAIL lat5_busy got busy=%b rv=%b required 1 0", busy_w[1], rv_w[1]);
        end
        press(1, 8'hEE);
        tests++;
        if (ovr_w[1] !== 1'b1 || rv_w[1] !== 1'b1 || res_w[1] !== 16'h0013 || a_w[1] !== 8'h10 || busy_w[1] !== 1'b0) begin
            fails++;
            $display("FAIL overrun_capture got ovr=%b rv=%b res=%h a=%h busy=%b required 1 1 0013 10 0",
                     ovr_w[1], rv_w[1], res_w[1], a_w[1], busy_w[1]);
        end
        tests++;
        if (gocnt[1] - g0 !== 1) begin
            fails++;
            $display("FAIL lat5_go_pulses got %0d required 1", gocnt[1] - g0);
        end
        press(1, 8'h77);
        tests++;
        if (ovr_w[1] !== 1'b0 || a_w[1] !== 8'h77 || rv_w[1] !== 1'b0 || res_w[1] !== 16'h0013) begin
            fails++;
            $display("FAIL overrun_clear got ovr=%b a=%h rv=%b res=%h required 0 77 0 0013", ovr_w[1], a_w[1], rv_w[1], res_w[1]);
        end
    endtask

    task automatic test_midop_reset();
        int          g0;
        bit          found;
        bit          ok;
        logic [7:0]  ra, rb;
        logic [3:0]  rop;
        logic [15:0] exp_res;
        do_reset();
        press(0, 8'h40);
        press(0, 8'h02);
        g0 = gocnt[0];
        found = 1'b0;
        sw = 8'h02;
        enter_w[0] = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 2) enter_w[0] = 1'b0;
            if (go_w[0]) begin
                found = 1'b1;
                break;
            end
        end
        enter_w[0] = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        tests++;
        if (!found || res_w[0] !== 16'h0000 || rv_w[0] !== 1'b0 || busy_w[0] !== 1'b0 || a_w[0] !== 8'h00 || gocnt[0] - g0 !== 1) begin
            fails++;
            $display("FAIL midop_reset got go_seen=%b res=%h rv=%b busy=%b a=%h go=%0d required 1 0000 0 0 00 1",
                     found, res_w[0], rv_w[0], busy_w[0], a_w[0], gocnt[0] - g0);
        end
        for (int n = 0; n < 120; n++) begin
            ra  = 8'($urandom_range(0, 255));
            rb  = 8'($urandom_range(0, 255));
            rop = 4'($urandom_range(0, 7));
            exp_res = stub(ra, rb, rop);
            press(0, ra);
            press(0, rb);
            press(0, {4'd0, rop});
            wait_rv(0, 10, ok);
            tests++;
            if (!ok || res_w[0] !== exp_res) begin
                fails++;
                $display("FAIL random_op[%0d] a=%h b=%h op=%h got ok=%b res=%h required 1 %h", n, ra, rb, rop, ok, res_w[0], exp_res);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_op();
        test_show_restart();
        test_illegal_op();
        test_overrun();
        test_midop_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout after %0d tests required completion", tests);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Front-end controller for the shared 8-bit-in / 16-bit-out ALU datapath. It collects operand A, operand B and an opcode from the 8-bit `switch` bank, one value per `enter` press, then issues the operation to the ALU. It captures the ALU result and holds it on `result` for display until the next operation starts. It sits between the board-level switch/button inputs and the ALU instance.

## Interface
Parameters:
- `NUM_OPS`, default 8: number of legal opcodes; codes `0..NUM_OPS-1` are accepted.
- `ALU_LATENCY`, default 1: cycles from the `alu_go` cycle to a valid `alu_result`; legal range 0–15.

Ports:
- `clk`  in  1  single system clock; all logic is rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `enter`  in  1  asynchronous push-button strobe; it must be high at ≥1 rising `clk` edge.
- `switch`  in  8  value entry; it must be stable from `enter` rise until 4 cycles after.
- `alu_result`  in  16  ALU output, sampled by this block.
- `alu_a`  out  8  operand A to the ALU.
- `alu_b`  out  8  operand B to the ALU.
- `alu_op`  out  4  opcode to the ALU, taken from `switch[3:0]`.
- `alu_go`  out  1  one-cycle issue strobe.
- `result`  out  16  captured ALU result.
- `result_valid`  out  1  high while `result` holds the current operation's value.
- `busy`  out  1  high in EXEC.
- `err`  out  1  illegal-opcode flag.
- `overrun`  out  1  sticky; an `enter` edge was ignored during EXEC.

## Operation
Input conditioning:
- `enter` passes through a 2-flop synchronizer, then a rising-edge detector, producing the one-cycle pulse `ent_p`.
- A held button yields exactly one `ent_p`.
- `switch` is sampled raw in the cycle `ent_p` is high.

State machine: LOAD_A → LOAD_B → LOAD_OP → EXEC → SHOW.
- LOAD_A, on `ent_p`: `alu_a<=switch`; clear `result_valid`, `err` and `overrun`; go to LOAD_B.
- LOAD_B, on `ent_p`: `alu_b<=switch`; go to LOAD_OP.
- LOAD_OP, on `ent_p`:
  - If `switch[3:0] < NUM_OPS` and `switch[7:4]==0`: `alu_op<=switch[3:0]`, clear `err`, go to EXEC.
  - Otherwise: set `err=1`, stay in LOAD_OP, leave `alu_op` unchanged.
- EXEC:
  - Assert `alu_go` in the first EXEC cycle only.
  - A 4-bit down-counter, loaded with `ALU_LATENCY`, counts down.
  - When the count reaches 0, `result<=alu_result`, `result_valid<=1`, go to SHOW.
  - With `ALU_LATENCY=0`, capture happens in the `alu_go` cycle itself, so EXEC lasts 1 cycle.
- SHOW, on `ent_p`: behaves exactly as LOAD_A with that `switch` value (A loaded, `result_valid` cleared), then goes to LOAD_B.

Other rules:
- `alu_a`, `alu_b` and `alu_op` hold their values from load until overwritten; they are stable through EXEC and SHOW.
- An `ent_p` during EXEC is ignored and sets `overrun`.
- Reset values: state LOAD_A; `alu_a`, `alu_b`, `alu_op`, `result` all 0; `alu_go`, `result_valid`, `busy`, `err`, `overrun` all 0; synchronizer and edge registers 0.
- A reset in any state, including mid-EXEC, aborts the operation. No `alu_go` or capture occurs on the cycle after reset.

## Timing
- `enter` sampled high at edge k: `ent_p` is high during cycle k+2→k+3, and the load takes effect at edge k+3.
- EXEC entry to `result_valid`: `ALU_LATENCY+1` cycles (edges).
- `alu_go` is high for exactly one cycle per accepted opcode.
- All outputs are registered, with no combinational path from inputs to outputs.
- Back-to-back `enter` presses need `enter` low for ≥1 sampled edge between them, or no new edge is detected.
- `ent_p` coinciding with the final EXEC cycle is ignored and sets `overrun`; the capture still completes.

## Test plan
- Reset: hold `rst` 5 cycles → all outputs 0, state LOAD_A; releasing `rst` with `enter` held high produces no load until `enter` falls and rises again.
- Full op with a bench multiplier stub (op 2 → `a*b`, `ALU_LATENCY=1`): press A=0x12, B=0x34, op=0x02 → one `alu_go` pulse; `result=0x03A8`, `result_valid=1` 2 edges after EXEC entry.
- Illegal opcode: op entry 0x09 (`NUM_OPS=8`) → `err=1`, no `alu_go`; next entry 0x03 → `err=0`, `alu_go` pulses.
- Overrun (`ALU_LATENCY=5`): press `enter` during EXEC → `overrun=1`; the result is still captured; the next press in SHOW clears `overrun` and loads A.
- SHOW restart: in SHOW press `switch=0xFF` → `alu_a=0xFF`, `result_valid=0`, state LOAD_B; `result` keeps its old value.
- Mid-op reset: assert `rst` in the cycle after `alu_go` → no capture, `result=0`, `result_valid=0`; 120 random A/B/op entries afterwards each match the stub model.
